// File: rtl/mem_request_unit_pkg.sv
// mem_req_pkg: shared state/port types and constants for mem_request_unit
package mem_req_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE} mrq_state_t;
  typedef enum logic {PORT_I, PORT_D} mrq_port_t;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;
endpackage

// File: rtl/mem_request_unit_if.sv
// mem_request_unit_if: CPU fetch/data ports and wishbone_manager request bus
interface mem_request_unit_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic i_req, i_ack, d_read, d_write, d_ack, mem_err, mgr_read, mgr_write, mgr_busy;
  logic [ADDR_W-1:0] i_adr, d_adr, mgr_adr;
  logic [DATA_W-1:0] i_rdat, d_wdat, d_rdat, mgr_dat, mgr_rdat;
  logic [3:0] d_sel, mgr_sel;
  modport master (
    input  i_req, i_adr, d_read, d_write, d_adr, d_wdat, d_sel, mgr_rdat, mgr_busy,
    output i_ack, i_rdat, d_ack, d_rdat, mem_err, mgr_read, mgr_write, mgr_adr, mgr_dat, mgr_sel
  );
  modport slave (
    output i_req, i_adr, d_read, d_write, d_adr, d_wdat, d_sel, mgr_rdat, mgr_busy,
    input  i_ack, i_rdat, d_ack, d_rdat, mem_err, mgr_read, mgr_write, mgr_adr, mgr_dat, mgr_sel
  );
endinterface

// File: rtl/mem_request_unit_priority.sv
// mem_req_priority: data-first grant; a fetch held off for STARVE_LIMIT data grants wins next
module mem_req_priority
  import mem_req_pkg::*;
#(parameter int STARVE_LIMIT = 2)
(
  input  logic      CLK,
  input  logic      nRST,
  input  logic      i_req,
  input  logic      d_req,
  input  logic      take,
  output mrq_port_t grant
);
  localparam int CW = $clog2(STARVE_LIMIT + 2);
  logic [CW-1:0] starve_cnt;
  assign grant = d_req && !(i_req && starve_cnt == CW'(STARVE_LIMIT)) ? PORT_D : PORT_I;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) starve_cnt <= '0;
    else if (take) starve_cnt <= grant == PORT_I ? '0 : i_req ? starve_cnt + 1'b1 : starve_cnt;
  end
endmodule

// File: rtl/mem_request_unit.sv
// mem_request_unit: arbitrates fetch and data ports into one wishbone_manager request.
// Define MEM_REQ_TIMEOUT_EN to bound the busy wait at TIMEOUT_CYCLES with mem_err.
module mem_request_unit
  import mem_req_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int STARVE_LIMIT   = 2,
  parameter int TIMEOUT_CYCLES = 256
)
(
  input logic               CLK,
  input logic               nRST,
  mem_request_unit_if.master bus
);
  mrq_state_t state, nxt;
  mrq_port_t grant, port_q;
  logic wr_q, tmo, err_q, any_req, rd_done, waiting, take;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] dat_q, i_rdat_q, d_rdat_q, cap;
  logic [3:0] sel_q;
  assign any_req = bus.i_req | bus.d_read | bus.d_write;
  assign take = state == IDLE && any_req;
  assign waiting = state == WAIT_HI || state == WAIT_LO;
  assign rd_done = state == WAIT_LO && !bus.mgr_busy;
  assign cap = tmo ? DATA_W'(TIMEOUT_DATA) : bus.mgr_rdat;
  mem_req_priority #(.STARVE_LIMIT(STARVE_LIMIT)) u_pri (
    .CLK(CLK), .nRST(nRST), .i_req(bus.i_req), .d_req(bus.d_read | bus.d_write),
    .take(take), .grant(grant)
  );
`ifdef MEM_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) tmo_cnt <= '0;
    else tmo_cnt <= waiting ? tmo_cnt + 1'b1 : '0;
  end
  // a normal completion on the same edge wins over the timeout
  assign tmo = waiting && !rd_done && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = TIMEOUT_CYCLES < 0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = any_req ? ISSUE : IDLE;
      ISSUE:   nxt = bus.mgr_busy ? WAIT_LO : WAIT_HI;
      WAIT_HI: nxt = bus.mgr_busy ? WAIT_LO : WAIT_HI;
      WAIT_LO: nxt = bus.mgr_busy ? WAIT_LO : DONE;
      default: nxt = IDLE;
    endcase
    if (tmo) nxt = DONE;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      port_q   <= PORT_I;
      wr_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      i_rdat_q <= '0;
      d_rdat_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= nxt;
      err_q <= tmo;
      if (take) begin
        port_q <= grant;
        wr_q   <= grant == PORT_D && bus.d_write;
        adr_q  <= grant == PORT_D ? bus.d_adr : bus.i_adr;
        dat_q  <= grant == PORT_D && bus.d_write ? bus.d_wdat : '0;
        sel_q  <= grant == PORT_D ? bus.d_sel : 4'hF;
      end
      if ((rd_done || tmo) && !wr_q && port_q == PORT_I) i_rdat_q <= cap;
      if ((rd_done || tmo) && !wr_q && port_q == PORT_D) d_rdat_q <= cap;
    end
  end
  assign bus.mgr_read  = state == ISSUE && !wr_q;
  assign bus.mgr_write = state == ISSUE && wr_q;
  assign bus.mgr_adr   = state == IDLE ? '0 : adr_q;
  assign bus.mgr_dat   = state == IDLE ? '0 : dat_q;
  assign bus.mgr_sel   = state == IDLE ? '0 : sel_q;
  assign bus.i_ack     = state == DONE && port_q == PORT_I;
  assign bus.d_ack     = state == DONE && port_q == PORT_D;
  assign bus.i_rdat    = i_rdat_q;
  assign bus.d_rdat    = d_rdat_q;
  assign bus.mem_err   = err_q;
endmodule

// File: tb/tb_mem_request_unit.sv
// tb_mem_request_unit: directed + random checks of mem_request_unit against a behavioural
// manager/memory and a reference memory; timeout case runs when MEM_REQ_TIMEOUT_EN is defined.
module tb_mem_request_unit;
  localparam logic [31:0] A0 = 32'h33000000;
  logic tb_CLK, tb_nRST, force_busy, long_busy;
  int checks = 0, failures = 0;
  mem_request_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_request_unit #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(2), .TIMEOUT_CYCLES(16)) dut (
    .CLK(tb_CLK), .nRST(tb_nRST), .bus(bus)
  );
  initial begin
    tb_CLK = 0;
    forever #5 tb_CLK = ~tb_CLK;
  end
  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] exp_i_rdat, exp_d_rdat, mon_adr, mon_dat, ra;
  logic [3:0] mon_sel;
  logic mon_wr, mon_act, ack_due, prev_busy, prev_pulse, pulse, gi, gd;
  int n, op, nd;
  logic [3:0] order;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] merge(input logic [31:0] old, w, input logic [3:0] s);
    logic [31:0] m = old;
    for (int b = 0; b < 4; b++) if (s[b]) m[8*b+:8] = w[8*b+:8];
    return m;
  endfunction
  function automatic logic [31:0] env_rd(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : 32'h0;
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction
  // behavioural wishbone_manager: random gap before busy, random busy length
  logic m_act_r, m_wr_r;
  logic [31:0] m_adr_r, m_dat_r;
  logic [3:0] m_sel_r;
  int m_pre, m_len;
  initial begin
    bus.mgr_busy = 0;
    bus.mgr_rdat = 0;
    m_act_r = 0;
    forever begin
      @(posedge tb_CLK);
      #1;
      if (!tb_nRST) begin
        bus.mgr_busy = 0;
        m_act_r = 0;
      end else if (force_busy) bus.mgr_busy = 1;
      else if (m_act_r) begin
        if (m_pre > 0) begin
          m_pre--;
          bus.mgr_busy = m_pre == 0;
        end else if (m_len > 1) m_len--;
        else begin
          bus.mgr_busy = 0;
          m_act_r = 0;
          if (m_wr_r) begin
            env_mem[m_adr_r] = merge(env_rd(m_adr_r), m_dat_r, m_sel_r);
            bus.mgr_rdat = $urandom;
          end else bus.mgr_rdat = env_rd(m_adr_r);
        end
      end else begin
        bus.mgr_busy = 0;
        if (bus.mgr_read || bus.mgr_write) begin
          m_act_r = 1;
          m_wr_r = bus.mgr_write;
          m_adr_r = bus.mgr_adr;
          m_dat_r = bus.mgr_dat;
          m_sel_r = bus.mgr_sel;
          m_pre = long_busy ? 1 : $urandom_range(0, 2);
          m_len = long_busy ? 6 : $urandom_range(1, 4);
          bus.mgr_busy = m_pre == 0;
        end
      end
    end
  end
  // bus monitor: one-cycle issue pulse, stable request, ack exactly one cycle after busy falls
  always @(negedge tb_CLK) begin
    if (!tb_nRST) begin
      mon_act = 0;
      ack_due = 0;
      prev_busy = 0;
      prev_pulse = 0;
    end else begin
      pulse = bus.mgr_read | bus.mgr_write;
      if (pulse) begin
        check("mgr_pulse_len", prev_pulse, 1'b0);
        mon_act = 1;
        mon_wr = bus.mgr_write;
        mon_adr = bus.mgr_adr;
        mon_dat = bus.mgr_dat;
        mon_sel = bus.mgr_sel;
      end else if (mon_act) begin
        check("mgr_adr_stable", bus.mgr_adr, mon_adr);
        check("mgr_dat_stable", {bus.mgr_sel, bus.mgr_dat}, {mon_sel, mon_dat});
      end
      if (!force_busy) check("ack_timing", bus.i_ack | bus.d_ack, ack_due);
      if (bus.i_ack | bus.d_ack) mon_act = 0;
      ack_due = mon_act && prev_busy && !bus.mgr_busy;
      prev_busy = bus.mgr_busy;
      prev_pulse = pulse;
    end
  end
  task automatic wait_ack(output logic ai, output logic ad);
    int k = 0;
    ai = 0;
    ad = 0;
    do begin
      @(negedge tb_CLK);
      ai = bus.i_ack;
      ad = bus.d_ack;
      k++;
    end while (!(ai || ad) && k < 100);
    check("ack_seen", ai | ad, 1'b1);
  endtask
  task automatic check_reset();
    check("rst_ctl", {bus.i_ack, bus.d_ack, bus.mem_err, bus.mgr_read, bus.mgr_write, bus.mgr_sel}, 0);
    check("rst_adr", bus.mgr_adr, 0);
    check("rst_dat", bus.mgr_dat, 0);
    check("rst_rdat", {bus.i_rdat, bus.d_rdat}, 0);
  endtask
  task automatic do_data(input logic wr, rd, input logic [31:0] adr, wdat, input logic [3:0] sel);
    logic ai, ad;
    bus.d_write = wr;
    bus.d_read = rd;
    bus.d_adr = adr;
    bus.d_wdat = wdat;
    bus.d_sel = sel;
    wait_ack(ai, ad);
    check("d_ack", ad, 1'b1);
    check("i_ack_quiet", ai, 1'b0);
    check("mem_err_quiet", bus.mem_err, 1'b0);
    check("mgr_dir", mon_wr, wr);
    check("mgr_adr", mon_adr, adr);
    check("mgr_sel", mon_sel, sel);
    if (wr) begin
      check("mgr_dat", mon_dat, wdat);
      check("d_rdat_hold", bus.d_rdat, exp_d_rdat);
      ref_mem[adr] = merge(ref_rd(adr), wdat, sel);
    end else begin
      exp_d_rdat = ref_rd(adr);
      check("d_rdat", bus.d_rdat, exp_d_rdat);
    end
    check("i_rdat_hold", bus.i_rdat, exp_i_rdat);
    bus.d_write = 0;
    bus.d_read = 0;
  endtask
  task automatic do_fetch(input logic [31:0] adr);
    logic ai, ad;
    bus.i_req = 1;
    bus.i_adr = adr;
    wait_ack(ai, ad);
    check("i_ack", ai, 1'b1);
    check("d_ack_quiet", ad, 1'b0);
    check("fetch_dir", mon_wr, 1'b0);
    check("fetch_adr", mon_adr, adr);
    check("fetch_sel", mon_sel, 4'hF);
    exp_i_rdat = ref_rd(adr);
    check("i_rdat", bus.i_rdat, exp_i_rdat);
    check("d_rdat_hold", bus.d_rdat, exp_d_rdat);
    bus.i_req = 0;
  endtask
  initial begin
    tb_nRST = 0;
    force_busy = 0;
    long_busy = 0;
    exp_i_rdat = 0;
    exp_d_rdat = 0;
    bus.i_req = 0;
    bus.i_adr = 0;
    bus.d_read = 0;
    bus.d_write = 0;
    bus.d_adr = 0;
    bus.d_wdat = 0;
    bus.d_sel = 0;
    repeat (3) @(negedge tb_CLK);
    check_reset();
    tb_nRST = 1;
    do_data(1'b1, 1'b0, A0, 32'h12345678, 4'hF);
    do_data(1'b0, 1'b1, A0, 32'h0, 4'hF);
    for (int i = 1; i < 8; i++) do_data(1'b1, 1'b0, A0 + 32'(4 * i), $urandom, 4'hF);
    for (int i = 0; i < 20; i++) begin
      op = $urandom_range(0, 2);
      ra = A0 + 32'(4 * $urandom_range(0, 7));
      if (op == 0) do_data(1'b1, 1'b0, ra, $urandom, 4'($urandom_range(1, 15)));
      else if (op == 1) do_data(1'b0, 1'b1, ra, 32'h0, 4'hF);
      else do_fetch(ra);
    end
    do_fetch(A0 + 32'h1c);
    // fetch and data requests held together: expect D, D, I, D
    bus.i_req = 1;
    bus.i_adr = A0 + 32'h8;
    bus.d_read = 1;
    bus.d_write = 0;
    bus.d_adr = A0;
    bus.d_sel = 4'hF;
    nd = 0;
    order = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ack(gi, gd);
      order = {order[2:0], gi};
      if (gd) begin
        exp_d_rdat = ref_rd(bus.d_adr);
        check("starve_d_rdat", bus.d_rdat, exp_d_rdat);
        nd++;
        bus.d_adr = bus.d_adr + 32'h4;
        if (nd == 3) bus.d_read = 0;
      end
      if (gi) begin
        exp_i_rdat = ref_rd(bus.i_adr);
        check("starve_i_rdat", bus.i_rdat, exp_i_rdat);
        bus.i_req = 0;
      end
    end
    check("grant_order", order, 4'b0010);
    bus.i_req = 0;
    bus.d_read = 0;
    do_data(1'b1, 1'b1, A0 + 32'h4, 32'hA5A5A5A5, 4'hF);
    do_data(1'b0, 1'b1, A0 + 32'h4, 32'h0, 4'hF);
    check("both_high_readback", bus.d_rdat, 32'hA5A5A5A5);
    // reset while the manager is busy
    long_busy = 1;
    bus.d_read = 1;
    bus.d_adr = A0 + 32'hC;
    bus.d_sel = 4'hF;
    n = 0;
    while (!bus.mgr_busy && n < 20) begin
      @(negedge tb_CLK);
      n++;
    end
    @(negedge tb_CLK);
    check("rst_setup_busy", bus.mgr_busy, 1'b1);
    tb_nRST = 0;
    #1;
    check_reset();
    exp_i_rdat = 0;
    exp_d_rdat = 0;
    bus.d_read = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge tb_CLK);
      check("rst_no_ack", bus.i_ack | bus.d_ack, 1'b0);
    end
    long_busy = 0;
    tb_nRST = 1;
    do_data(1'b0, 1'b1, A0 + 32'hC, 32'h0, 4'hF);
    do_fetch(A0 + 32'h4);
`ifdef MEM_REQ_TIMEOUT_EN
    force_busy = 1;
    bus.d_read = 1;
    bus.d_adr = A0;
    bus.d_sel = 4'hF;
    n = 0;
    while (!bus.mgr_read && n < 10) begin
      @(negedge tb_CLK);
      n++;
    end
    n = 0;
    do begin
      @(negedge tb_CLK);
      n++;
    end while (!bus.d_ack && n < 60);
    check("tmo_latency", n, 17);
    check("tmo_err", bus.mem_err, 1'b1);
    check("tmo_rdat", bus.d_rdat, 32'hDEADBEEF);
    exp_d_rdat = 32'hDEADBEEF;
    bus.d_read = 0;
    force_busy = 0;
    @(negedge tb_CLK);
    check("tmo_err_pulse", bus.mem_err, 1'b0);
    repeat (2) @(negedge tb_CLK);
    do_data(1'b0, 1'b1, A0, 32'h0, 4'hF);
`endif
    repeat (3) @(negedge tb_CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
